axis_1553_encoder: RTL and testbench
====================================

Name: axis_1553_encoder

Overview:
- AXI-Stream slave to MIL-STD-1553 Manchester-II encoder.
- Accepts one 16-bit word per transfer, plus a tuser control byte.
- Serialises the word at 1 Mbit/s as sync + 16 data bits + parity on a differential pair, with a transmit enable.
- Sits between the 1553 core/packet logic and the bus transceiver.

Parameters:
- clock_speed, 20000000: aclk frequency in Hz. Must be an integer multiple of 2 MHz and at least 2 MHz. Half-bit period HB = clock_speed/2000000 clocks (10 at default).

Ports:
- aclk  input  1  system clock; all logic on rising edge.
- arst  input  1  reset, synchronous, active-high.
- s_axis_tdata  input  16  word to transmit, MSB first.
- s_axis_tvalid  input  1  word valid.
- s_axis_tuser  input  8  control byte:
  - [7:5] sync type: 100 = command/status, 010 = data; any other value is treated as data.
  - [4] reserved.
  - [3] post-word delay enable.
  - [2:1] reserved.
  - [0] parity select: 1 = odd, 0 = even (fault injection).
- s_axis_tready  output  1  ready for a word.
- diff  output  2  [1] = positive leg, [0] = negative leg; always complementary while enabled.
- en_diff  output  1  transmitter enable; high while a word is driven.

Behaviour:
- Reset, synchronous active-high, on any cycle including mid-word:
  - state=IDLE, diff=00, en_diff=0, s_axis_tready=0.
  - The word in flight is abandoned; nothing resumes after reset.
- Line level L drives diff={L,~L} with en_diff=1.
- Idle and delay: diff=00, en_diff=0.
- States:
  - IDLE: tready=1. On tvalid&&tready, latch tdata/tuser and go to SYNC next cycle. First diff level appears the cycle after acceptance. tready=0 from the cycle after acceptance.
  - SYNC: 6 half-bits (3 bit times).
    - Command/status: L=1 for 3 half-bits, then L=0 for 3 half-bits.
    - Data: L=0 for 3, then L=1 for 3.
  - DATA: 16 bits, tdata[15] first. Each bit is 2 half-bits: logic 1 = L=1 then L=0; logic 0 = L=0 then L=1.
  - PARITY: 1 bit, Manchester-coded like data.
    - Odd mode: bit makes the total count of ones in data+parity odd (parity = ~^tdata).
    - Even mode: parity = ^tdata.
  - DELAY (only if latched tuser[3]=1): diff=00, en_diff=0 for 4 µs (8*HB clocks), then IDLE.
- Word duration is 40 half-bits = 40*HB clocks (400 at default).
- Each half-bit is held exactly HB clocks; one counter counts 0..HB-1 and a half-bit index counts 0..39.
- Back-to-back words with tuser[3]=0:
  - tready is asserted during the final clock of the parity second half.
  - If tvalid is high in that cycle, the new word is accepted and its sync starts the next cycle. en_diff stays 1 with no gap.
  - Otherwise go to IDLE with en_diff=0.
- With tuser[3]=1, tready stays 0 through DELAY and reasserts on entering IDLE.
- tdata/tuser changes while tready=0 have no effect on the word in flight.
- tvalid deasserting while idle is legal; no transfer occurs.

Test Plan:
- Reset held 100 ns, then released with tvalid=0 → diff=00, en_diff=0 throughout reset; tready=1 in the first IDLE cycle after release.
- tdata=FFFF, tuser=8F at 20 MHz:
  - Command sync: diff=10 for 30 clocks, then 01 for 30.
  - 16 bits each 10,01 (10 clocks per half).
  - Parity 1 (10,01).
  - Then 80 clocks of diff=00 with en_diff=0; tready reasserts at clock 480 after acceptance.
- tdata=0001, tuser=40 (data sync, even parity, no delay):
  - Sync is 01 for 30 clocks, then 10 for 30.
  - Bits 15..1 are 01,10; bit 0 is 10,01.
  - Parity 1 (10,01).
  - Total 400 clocks.
- tdata=0000, tuser=81, tvalid held high continuously:
  - Parity bit 1.
  - Consecutive words with en_diff never dropping.
  - tready high exactly 1 cycle per 400 clocks.
  - tdata incremented per accepted transfer appears in order 0000, 0001, ...
- Assert arst mid-DATA → next cycle diff=00, en_diff=0, tready=0. After release, a new word is encoded from its sync with correct timing.
- tuser=E1 (undefined sync type) → transmitted with data sync pattern (01 for 30 clocks, then 10).

Source files
------------

// File: rtl/axis_1553_encoder.sv
// rtl/axis_1553_encoder.sv - AXI-Stream slave to MIL-STD-1553 Manchester-II word encoder
//
// Takes one 16-bit word per AXI-Stream transfer and sends it as
// sync + 16 data bits (MSB first) + parity on a differential pair.
// The bit rate is 1 Mbit/s, so one half-bit lasts HB = clock_speed/2 MHz clocks.
//
// Ports:
//   aclk           system clock, rising edge
//   arst           synchronous active-high reset
//   s_axis_tdata   word to transmit
//   s_axis_tvalid  word valid
//   s_axis_tuser   [7:5] sync type (100 = command/status, otherwise data),
//                  [3] post-word 4 us delay enable, [0] parity (1 = odd, 0 = even)
//   s_axis_tready  ready for a word
//   diff           {positive leg, negative leg}; 00 while idle or delaying
//   en_diff        transmitter enable
module axis_1553_encoder #(
  parameter int clock_speed = 20000000
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic [7:0]  s_axis_tuser,
  output logic        s_axis_tready,
  output logic [1:0]  diff,
  output logic        en_diff
);

  localparam int HB = clock_speed / 2000000;
  // One counter covers both a half-bit and the 8-half-bit post-word delay.
  localparam int CW = $clog2(8 * HB);
  localparam logic [CW-1:0] HB_LAST  = CW'(HB - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(8 * HB - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XMIT  = 2'd1;
  localparam logic [1:0] ST_DELAY = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [5:0]    hb_idx;     // 0..5 sync, 6..37 data, 38..39 parity
  logic [16:0]   frame;      // {data, parity}, bit 16 sent first
  logic          sync_cmd;
  logic          dly_en;

  logic          last_tick;
  logic          line;
  logic [5:0]    sub;
  logic [4:0]    pos;
  logic          load_par;
  logic          unused_tuser;

  assign unused_tuser = ^{s_axis_tuser[4], s_axis_tuser[2:1]};

  assign load_par  = s_axis_tuser[0] ? ~^s_axis_tdata : ^s_axis_tdata;
  assign last_tick = (cnt == HB_LAST) && (hb_idx == 6'd39);

  // Ready in idle, and in the final clock of the parity bit so that words
  // without a delay can follow each other with no gap on the line.
  assign s_axis_tready = !arst &&
                         ((state == ST_IDLE) ||
                          (state == ST_XMIT && last_tick && !dly_en));

  always_ff @(posedge aclk) begin
    if (arst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hb_idx   <= '0;
      frame    <= '0;
      sync_cmd <= 1'b0;
      dly_en   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_axis_tvalid) begin
            frame    <= {s_axis_tdata, load_par};
            sync_cmd <= (s_axis_tuser[7:5] == 3'b100);
            dly_en   <= s_axis_tuser[3];
            cnt      <= '0;
            hb_idx   <= '0;
            state    <= ST_XMIT;
          end
        end
        ST_XMIT: begin
          if (cnt == HB_LAST) begin
            cnt <= '0;
            if (hb_idx == 6'd39) begin
              hb_idx <= '0;
              if (dly_en) begin
                state <= ST_DELAY;
              end else if (s_axis_tvalid) begin
                frame    <= {s_axis_tdata, load_par};
                sync_cmd <= (s_axis_tuser[7:5] == 3'b100);
                dly_en   <= s_axis_tuser[3];
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              hb_idx <= hb_idx + 6'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DELAY: begin
          if (cnt == DLY_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Manchester level: first half of a bit carries the bit, second half its inverse.
  assign sub = hb_idx - 6'd6;
  assign pos = sub[5:1];

  always_comb begin
    line = 1'b0;
    if (hb_idx < 6'd6) begin
      line = sync_cmd ? (hb_idx < 6'd3) : (hb_idx >= 6'd3);
    end else begin
      line = frame[5'd16 - pos] ^ sub[0];
    end
  end

  assign en_diff = (state == ST_XMIT);
  assign diff    = en_diff ? {line, ~line} : 2'b00;

endmodule

// File: tb/tb_axis_1553_encoder.sv
// tb/tb_axis_1553_encoder.sv - scoreboard bench for axis_1553_encoder
`timescale 1ns/1ps
module tb_axis_1553_encoder;

  localparam int HB = 10;

  logic        tb_data_clk = 1'b0;
  logic        arst = 1'b1;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic [7:0]  s_axis_tuser = '0;
  logic        s_axis_tready;
  logic [1:0]  diff;
  logic        en_diff;

  int n_total = 0;
  int n_bad = 0;

  // Each entry is the expected {tready, en_diff, diff} for one clock.
  logic [3:0] exp_q[$];
  logic       arst_prev = 1'b0;

  always #25 tb_data_clk = ~tb_data_clk;

  axis_1553_encoder #(.clock_speed(20000000)) dut (
    .aclk(tb_data_clk),
    .arst(arst),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tuser(s_axis_tuser),
    .s_axis_tready(s_axis_tready),
    .diff(diff),
    .en_diff(en_diff)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_level(input logic lvl, input bit last_rdy);
    for (int i = 0; i < HB; i++)
      exp_q.push_back({last_rdy && (i == HB - 1), 1'b1, lvl, ~lvl});
  endtask

  task automatic push_word(input logic [15:0] d, input logic [7:0] u);
    logic par;
    logic cmd;
    cmd = (u[7:5] == 3'b100);
    par = u[0] ? ~^d : ^d;
    for (int h = 0; h < 3; h++) push_level(cmd, 1'b0);
    for (int h = 0; h < 3; h++) push_level(~cmd, 1'b0);
    for (int b = 15; b >= 0; b--) begin
      push_level(d[b], 1'b0);
      push_level(~d[b], 1'b0);
    end
    push_level(par, 1'b0);
    push_level(~par, !u[3]);
    if (u[3])
      for (int i = 0; i < 8 * HB; i++) exp_q.push_back(4'b0000);
  endtask

  always @(negedge tb_data_clk) begin
    logic [3:0] g;
    logic [3:0] e;
    g = {s_axis_tready, en_diff, diff};
    if (arst) begin
      if (arst_prev) check("rst", 32'(g), 32'h0);
      else check("rst_rdy", 32'(s_axis_tready), 32'h0);
      exp_q.delete();
    end else begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b1000;
      check("line", 32'(g), 32'(e));
      if (e[3] && s_axis_tvalid) push_word(s_axis_tdata, s_axis_tuser);
    end
    arst_prev <= arst;
  end

  task automatic send(input logic [15:0] d, input logic [7:0] u, input bit keep);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    @(negedge tb_data_clk);
    while (!s_axis_tready && n < 2000) begin
      @(negedge tb_data_clk);
      n++;
    end
    check("accept", 32'(s_axis_tready), 32'h1);
    @(posedge tb_data_clk);
    #1;
    if (!keep) begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 16'($urandom);
      s_axis_tuser  = 8'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge tb_data_clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'h0);
    repeat (3) @(posedge tb_data_clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge tb_data_clk);
    #1;
    arst = 1'b0;
    repeat (4) @(posedge tb_data_clk);
    #1;

    send(16'hFFFF, 8'h8F, 1'b0);
    drain();

    send(16'h0001, 8'h40, 1'b0);
    drain();

    for (int i = 0; i < 4; i++) send(16'(i), 8'h81, 1'b1);
    s_axis_tvalid = 1'b0;
    drain();

    send(16'h1234, 8'h00, 1'b0);
    repeat (120) @(posedge tb_data_clk);
    #1;
    arst = 1'b1;
    repeat (2) @(posedge tb_data_clk);
    #1;
    arst = 1'b0;
    send(16'hA5C3, 8'h80, 1'b0);
    drain();

    send(16'h0F0F, 8'hE1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
